// File: rtl/k12_alu_ctrl.sv
// k12_alu_ctrl: runs one ALU operation at a time. It reads operands from the
// single-port synchronous register file, drives the combinational k12_alu,
// writes the result back and pulses done.
module k12_alu_ctrl #(
    parameter int unsigned REGW  = 8,
    parameter int unsigned RADDR = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [15:0]      req_inst,
    input  logic [RADDR-1:0] req_rd,
    input  logic [RADDR-1:0] req_rs,
    input  logic             req_imm,
    input  logic             req_wb,
    output logic [RADDR-1:0] rf_addr,
    output logic             rf_we,
    output logic [REGW-1:0]  rf_wdata,
    input  logic [REGW-1:0]  rf_rdata,
    output logic [REGW-1:0]  alu_a,
    output logic [REGW-1:0]  alu_b,
    output logic [15:0]      alu_inst,
    input  logic [REGW-1:0]  alu_res,
    input  logic             alu_cond,
    output logic             done,
    output logic             cond_flag
);

    localparam int unsigned INSTW = 16;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD_A = 3'd1,
        S_RD_B = 3'd2,
        S_EXEC = 3'd3,
        S_WB   = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [INSTW-1:0]   inst_q, inst_d;
    logic [RADDR-1:0]   rd_q, rd_d;
    logic [RADDR-1:0]   rs_q, rs_d;
    logic               imm_q, imm_d;
    logic               wb_q, wb_d;
    logic [REGW-1:0]    a_q, a_d;
    logic [REGW-1:0]    b_q, b_d;
    logic [INSTW-1:0]   alu_inst_q, alu_inst_d;
    logic [REGW-1:0]    res_q, res_d;
    logic               cond_q, cond_d;
    logic               cond_flag_q, cond_flag_d;
    logic [RADDR-1:0]   rf_addr_q, rf_addr_d;
    logic               rf_we_q, rf_we_d;
    logic [REGW-1:0]    rf_wdata_q, rf_wdata_d;
    logic               done_q, done_d;

    logic               accept_c;
    logic [REGW-1:0]    op_a_c;
    logic [REGW-1:0]    op_b_c;

    // Handshake readiness is a pure decode of the state.
    assign req_ready = (state_q == S_IDLE) || (state_q == S_WB);
    assign accept_c  = req_valid && req_ready;

    // The operand read last arrives from the register file during EXEC itself:
    // rs for the register form, rd for the immediate form.
    assign op_a_c = imm_q ? rf_rdata : a_q;
    assign op_b_c = imm_q ? inst_q[REGW-1:0] : rf_rdata;

    // ALU inputs follow the live operands in EXEC and hold their last values elsewhere.
    assign alu_a    = (state_q == S_EXEC) ? op_a_c : a_q;
    assign alu_b    = (state_q == S_EXEC) ? op_b_c : b_q;
    assign alu_inst = (state_q == S_EXEC) ? inst_q : alu_inst_q;

    assign rf_addr   = rf_addr_q;
    assign rf_we     = rf_we_q;
    assign rf_wdata  = rf_wdata_q;
    assign done      = done_q;
    assign cond_flag = cond_flag_q;

    // Next-state, operand capture and registered output decode.
    always_comb begin
        state_d     = state_q;
        inst_d      = inst_q;
        rd_d        = rd_q;
        rs_d        = rs_q;
        imm_d       = imm_q;
        wb_d        = wb_q;
        a_d         = a_q;
        b_d         = b_q;
        alu_inst_d  = alu_inst_q;
        res_d       = res_q;
        cond_d      = cond_q;
        cond_flag_d = cond_flag_q;
        rf_addr_d   = rf_addr_q;
        rf_we_d     = 1'b0;
        rf_wdata_d  = rf_wdata_q;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    inst_d  = req_inst;
                    rd_d    = req_rd;
                    rs_d    = req_rs;
                    imm_d   = req_imm;
                    wb_d    = req_wb;
                    state_d = S_RD_A;
                end
            end
            S_RD_A: begin
                state_d = imm_q ? S_EXEC : S_RD_B;
            end
            S_RD_B: begin
                a_d     = rf_rdata;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                a_d        = op_a_c;
                b_d        = op_b_c;
                alu_inst_d = inst_q;
                res_d      = alu_res;
                cond_d     = alu_cond;
                state_d    = S_WB;
            end
            S_WB: begin
                cond_flag_d = cond_q;
                if (accept_c) begin
                    inst_d  = req_inst;
                    rd_d    = req_rd;
                    rs_d    = req_rs;
                    imm_d   = req_imm;
                    wb_d    = req_wb;
                    state_d = S_RD_A;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Register-file side outputs are decoded from the state being entered.
        case (state_d)
            S_IDLE: rf_addr_d = '0;
            S_RD_A: rf_addr_d = rd_d;
            S_RD_B: rf_addr_d = rs_q;
            S_WB: begin
                rf_addr_d  = rd_q;
                rf_we_d    = wb_q;
                rf_wdata_d = res_d;
                done_d     = 1'b1;
            end
            default: rf_addr_d = rf_addr_q;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            inst_q      <= '0;
            rd_q        <= '0;
            rs_q        <= '0;
            imm_q       <= 1'b0;
            wb_q        <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            alu_inst_q  <= '0;
            res_q       <= '0;
            cond_q      <= 1'b0;
            cond_flag_q <= 1'b0;
            rf_addr_q   <= '0;
            rf_we_q     <= 1'b0;
            rf_wdata_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            inst_q      <= inst_d;
            rd_q        <= rd_d;
            rs_q        <= rs_d;
            imm_q       <= imm_d;
            wb_q        <= wb_d;
            a_q         <= a_d;
            b_q         <= b_d;
            alu_inst_q  <= alu_inst_d;
            res_q       <= res_d;
            cond_q      <= cond_d;
            cond_flag_q <= cond_flag_d;
            rf_addr_q   <= rf_addr_d;
            rf_we_q     <= rf_we_d;
            rf_wdata_q  <= rf_wdata_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: tb/tb_k12_alu_ctrl.sv
// Directed bench for k12_alu_ctrl with a small register file and ALU stand-in.
module tb_k12_alu_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_inst;
    logic [2:0]  req_rd;
    logic [2:0]  req_rs;
    logic        req_imm;
    logic        req_wb;
    logic [2:0]  rf_addr;
    logic        rf_we;
    logic [7:0]  rf_wdata;
    logic [7:0]  rf_rdata;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [15:0] alu_inst;
    logic [7:0]  alu_res;
    logic        alu_cond;
    logic        done;
    logic        cond_flag;

    logic        rf_load;
    logic [7:0]  rf_mem [8];

    int errors = 0;
    int checks = 0;

    k12_alu_ctrl #(.REGW(8), .RADDR(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_inst  (req_inst),
        .req_rd    (req_rd),
        .req_rs    (req_rs),
        .req_imm   (req_imm),
        .req_wb    (req_wb),
        .rf_addr   (rf_addr),
        .rf_we     (rf_we),
        .rf_wdata  (rf_wdata),
        .rf_rdata  (rf_rdata),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_inst  (alu_inst),
        .alu_res   (alu_res),
        .alu_cond  (alu_cond),
        .done      (done),
        .cond_flag (cond_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous register file: read data appears the cycle after the address.
    always @(posedge clk) begin
        if (rf_load) begin
            rf_mem[0] <= 8'h00;
            rf_mem[1] <= 8'h7E;
            rf_mem[2] <= 8'h01;
            rf_mem[3] <= 8'h80;
            rf_mem[4] <= 8'h10;
            rf_mem[5] <= 8'h22;
            rf_mem[6] <= 8'h66;
            rf_mem[7] <= 8'h00;
        end else if (rf_we) begin
            rf_mem[rf_addr] <= rf_wdata;
        end
        rf_rdata <= rf_mem[rf_addr];
    end

    // ALU stand-in: op 1 add (cond=carry), op 2 subtract (cond=borrow), else pass a.
    always_comb begin
        alu_res  = alu_a;
        alu_cond = 1'b0;
        case (alu_inst[11:8])
            4'h1: {alu_cond, alu_res} = {1'b0, alu_a} + {1'b0, alu_b};
            4'h2: {alu_cond, alu_res} = {1'b0, alu_a} - {1'b0, alu_b};
            default: alu_res = alu_a;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic drive_req(input logic [15:0] inst, input logic [2:0] rd,
                             input logic [2:0] rs, input logic imm, input logic wb);
        req_valid = 1'b1;
        req_inst  = inst;
        req_rd    = rd;
        req_rs    = rs;
        req_imm   = imm;
        req_wb    = wb;
    endtask

    initial begin
        int n;
        int dones;
        rst = 1'b1;
        rf_load = 1'b1;
        req_valid = 1'b0;
        req_inst = '0;
        req_rd = '0;
        req_rs = '0;
        req_imm = 1'b0;
        req_wb = 1'b0;
        repeat (2) cyc();
        rst = 1'b0;
        rf_load = 1'b0;

        // Reset state
        check("rst_ready", 32'(req_ready), 32'h1);
        check("rst_we", 32'(rf_we), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_cond", 32'(cond_flag), 32'h0);
        check("rst_alu_inst", 32'(alu_inst), 32'h0);
        check("rst_rf_addr", 32'(rf_addr), 32'h0);

        // Register form: R1 = 0x7E + 0x01
        drive_req(16'h0100, 3'd1, 3'd2, 1'b0, 1'b1);
        cyc();
        req_valid = 1'b0;
        check("reg_rda_addr", 32'(rf_addr), 32'h1);
        check("reg_rda_ready", 32'(req_ready), 32'h0);
        cyc();
        check("reg_rdb_addr", 32'(rf_addr), 32'h2);
        cyc();
        check("reg_exec_a", 32'(alu_a), 32'h7E);
        check("reg_exec_b", 32'(alu_b), 32'h01);
        check("reg_exec_inst", 32'(alu_inst), 32'h0100);
        cyc();
        check("reg_wb_done", 32'(done), 32'h1);
        check("reg_wb_we", 32'(rf_we), 32'h1);
        check("reg_wb_addr", 32'(rf_addr), 32'h1);
        check("reg_wb_data", 32'(rf_wdata), 32'h7F);
        check("reg_wb_ready", 32'(req_ready), 32'h1);
        cyc();
        check("reg_idle_done", 32'(done), 32'h0);
        check("reg_idle_we", 32'(rf_we), 32'h0);
        check("reg_idle_addr", 32'(rf_addr), 32'h0);
        check("reg_cond_flag", 32'(cond_flag), 32'h0);
        check("reg_r1", 32'(rf_mem[1]), 32'h7F);

        // Immediate form: R3 = 0x80 - 0xFF, no write-back
        drive_req(16'h02FF, 3'd3, 3'd0, 1'b1, 1'b0);
        cyc();
        req_valid = 1'b0;
        check("imm_rda_addr", 32'(rf_addr), 32'h3);
        cyc();
        check("imm_exec_a", 32'(alu_a), 32'h80);
        check("imm_exec_b", 32'(alu_b), 32'hFF);
        check("imm_exec_inst", 32'(alu_inst), 32'h02FF);
        cyc();
        check("imm_wb_done", 32'(done), 32'h1);
        check("imm_wb_we", 32'(rf_we), 32'h0);
        check("imm_wb_data", 32'(rf_wdata), 32'h81);
        cyc();
        check("imm_cond_flag", 32'(cond_flag), 32'h1);
        check("imm_r3", 32'(rf_mem[3]), 32'h80);
        check("imm_hold_b", 32'(alu_b), 32'hFF);
        check("imm_idle_done", 32'(done), 32'h0);

        // Back-to-back: op1 R4 = 0x10 + 5, op2 R4 = R4 + R1 accepted on op1's WB edge
        drive_req(16'h0105, 3'd4, 3'd0, 1'b1, 1'b1);
        cyc();
        check("b2b_rda_addr", 32'(rf_addr), 32'h4);
        drive_req(16'h0100, 3'd4, 3'd1, 1'b0, 1'b1);
        cyc();
        check("b2b_exec1_a", 32'(alu_a), 32'h10);
        check("b2b_exec1_b", 32'(alu_b), 32'h05);
        cyc();
        check("b2b_wb1_done", 32'(done), 32'h1);
        check("b2b_wb1_data", 32'(rf_wdata), 32'h15);
        check("b2b_wb1_ready", 32'(req_ready), 32'h1);
        n = 0;
        while (n < 10) begin
            cyc();
            n++;
            if (n == 1) begin
                req_valid = 1'b0;
                check("b2b_rda2_addr", 32'(rf_addr), 32'h4);
                check("b2b_cond1", 32'(cond_flag), 32'h0);
            end
            if (n == 3) begin
                check("b2b_exec2_a", 32'(alu_a), 32'h15);
                check("b2b_exec2_b", 32'(alu_b), 32'h7F);
            end
            if (done) break;
        end
        check("b2b_done_gap", 32'(n), 32'h4);
        check("b2b_wb2_data", 32'(rf_wdata), 32'h94);
        cyc();
        check("b2b_r4", 32'(rf_mem[4]), 32'h94);

        // Reset during EXEC discards the operation
        drive_req(16'h0100, 3'd5, 3'd1, 1'b0, 1'b1);
        cyc();
        req_valid = 1'b0;
        cyc();
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("mid_rst_done", 32'(done), 32'h0);
        check("mid_rst_we", 32'(rf_we), 32'h0);
        check("mid_rst_ready", 32'(req_ready), 32'h1);
        check("mid_rst_addr", 32'(rf_addr), 32'h0);
        check("mid_rst_inst", 32'(alu_inst), 32'h0);
        cyc();
        check("mid_rst_done2", 32'(done), 32'h0);
        check("mid_rst_we2", 32'(rf_we), 32'h0);
        check("mid_rst_r5", 32'(rf_mem[5]), 32'h22);

        // Valid pulsed while busy is ignored: R2 = 0x01 - 0x7F
        drive_req(16'h0200, 3'd2, 3'd1, 1'b0, 1'b1);
        cyc();
        req_valid = 1'b0;
        cyc();
        drive_req(16'h0100, 3'd6, 3'd6, 1'b0, 1'b1);
        cyc();
        req_valid = 1'b0;
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (done) begin
                dones++;
                check("wd_wb_data", 32'(rf_wdata), 32'h82);
                check("wd_wb_addr", 32'(rf_addr), 32'h2);
            end
        end
        check("wd_done_count", 32'(dones), 32'h1);
        check("wd_r2", 32'(rf_mem[2]), 32'h82);
        check("wd_r6", 32'(rf_mem[6]), 32'h66);
        check("wd_cond_flag", 32'(cond_flag), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
